mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, max cycles spent in ACCESS waiting for MFC before abort (range 1..15).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 f_req  input  1  fetch requester read request, level, held until f_done.
REQ-005 f_addr  input  16  fetch address.
REQ-006 f_rdata  output  16  last data read for fetch requester.
REQ-007 f_done  output  1  one-cycle completion pulse to fetch requester.
REQ-008 f_err  output  1  one-cycle timeout flag, coincident with f_done.
REQ-009 d_req  input  1  data requester request, level, held until d_done.
REQ-010 d_we  input  1  data requester direction: 1 write, 0 read.
REQ-011 d_addr  input  16  data address.
REQ-012 d_wdata  input  16  data write value.
REQ-013 d_rdata  output  16  last data read for data requester.
REQ-014 d_done  output  1  one-cycle completion pulse to data requester.
REQ-015 d_err  output  1  one-cycle timeout flag, coincident with d_done.
REQ-016 mem_addr  output  16  registered memory address.
REQ-017 mem_wdata  output  16  registered memory write data.
REQ-018 mem_rdata  input  16  memory read data, valid when MFC=1.
REQ-019 mem_en  output  1  memory enable, high only in ACCESS.
REQ-020 R_W  output  1  1 read, 0 write; fetch always read.
REQ-021 MFC  input  1  memory function complete.
REQ-022 busy  output  1  high whenever state is not IDLE.
REQ-023 grant  output  1  current/last owner: 0 fetch, 1 data.

Function
REQ-024 FSM states: IDLE, ADDR, ACCESS, CAPTURE, DONE; all outputs registered.
REQ-025 IDLE: if any req high, arbitrate, latch owner into grant, go ADDR; else stay.
REQ-026 Arbitration round-robin: both requesting -> grant the requester not granted last; single requester -> granted directly.
REQ-027 ADDR: mem_addr, mem_wdata (data writes only), R_W loaded from owner; go ACCESS.
REQ-028 ACCESS: mem_en=1; MFC=1 sampled -> CAPTURE; else timeout counter increments; counter reaching TIMEOUT_CYCLES -> DONE with error flag set.
REQ-029 CAPTURE: on read, mem_rdata latched into owner's rdata register; on write, rdata unchanged; mem_en=0; go DONE.
REQ-030 DONE: owner's done pulses high one cycle, err high only if timed out; go IDLE.
REQ-031 Minimum latency: request sampled in IDLE at edge N, done high during cycle after edge N+4 when MFC is high in first ACCESS cycle.
REQ-032 Request still high in IDLE after its done is a new request; arbitration priority then favours the other requester.
REQ-033 Request deasserted mid-transaction is ignored; transaction completes normally.
REQ-034 Timeout: rdata unchanged, memory outputs return idle, timeout counter cleared on every ADDR entry.
REQ-035 f_done and d_done never high together; mem_en never high outside ACCESS.

Reset
REQ-036 reset low asynchronously forces IDLE, mem_en=0, R_W=1, all done/err=0, mem_addr, mem_wdata, f_rdata, d_rdata = 0x0000, timeout counter 0, grant=1 (so fetch wins first conflict).
REQ-037 reset asserted mid-transaction aborts it without any done pulse; operation resumes from IDLE on first edge after release.

Structure
REQ-038 Shared package mem_ctrl_pkg holds FSM state encoding, R_W encoding constants, TIMEOUT_CYCLES default.
REQ-039 One sub-module arb2_rr: two-input round-robin arbiter with last-grant register.

Verification
REQ-040 Fetch read f_addr=0x0010, memory returns 0x1234 with MFC in first ACCESS cycle -> f_rdata=0x1234, f_done pulse 4 cycles after request sampled.
REQ-041 Data write d_addr=0x0200, d_wdata=0xBEEF -> R_W=0, mem_en high one cycle, d_done pulse, d_rdata unchanged 0x0000.
REQ-042 f_req and d_req held high after reset -> grant sequence fetch, data, fetch, data.
REQ-043 MFC held low -> mem_en high exactly 15 cycles, then done+err pulse, rdata unchanged.
REQ-044 reset low during ACCESS -> mem_en drops immediately, no done pulse, next request served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, bus direction
// constants, requester identifiers and the default timeout.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/arb2_rr.sv
// Two-input round-robin arbiter. The grant register doubles as the
// "last owner" memory, so a conflict always goes to the other requester.
module arb2_rr (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant
);

  logic grant_next;

  always_comb begin
    grant_next = grant;
    if (req0 && req1) begin
      grant_next = ~grant;
    end else if (req1) begin
      grant_next = 1'b1;
    end else if (req0) begin
      grant_next = 1'b0;
    end
  end

  // Reset to requester 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= 1'b1;
    end else if (update) begin
      grant <= grant_next;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between a fetch requester and a data requester.
// Five-state transaction FSM with round-robin arbitration and MFC timeout.
module mem_bus_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic [15:0] f_rdata,
  output logic        f_done,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        R_W,
  input  logic        MFC,
  output logic        busy,
  output logic        grant
);

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  tmo_cnt, tmo_cnt_next;
  logic        timed_out, timed_out_next;
  logic [15:0] cap_data, cap_data_next;
  logic [15:0] mem_addr_next, mem_wdata_next, f_rdata_next, d_rdata_next;
  logic        mem_en_next, r_w_next, busy_next;
  logic        f_done_next, f_err_next, d_done_next, d_err_next;
  logic        arb_update;

  assign arb_update = (state == S_IDLE) && (f_req || d_req);

  arb2_rr u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (f_req),
    .req1   (d_req),
    .update (arb_update),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (f_req || d_req) state_next = S_ADDR;
      S_ADDR:    state_next = S_ACCESS;
      S_ACCESS: begin
        if (MFC) begin
          state_next = S_CAPTURE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_DONE;
        end
      end
      S_CAPTURE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Each state's action lands on the edge leaving it, so every output is a
  // flop; mem_en and busy track the state being entered.
  always_comb begin
    tmo_cnt_next   = tmo_cnt;
    timed_out_next = timed_out;
    cap_data_next  = cap_data;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    f_rdata_next   = f_rdata;
    d_rdata_next   = d_rdata;
    r_w_next       = R_W;
    mem_en_next    = (state_next == S_ACCESS);
    busy_next      = (state_next != S_IDLE);
    f_done_next    = 1'b0;
    f_err_next     = 1'b0;
    d_done_next    = 1'b0;
    d_err_next     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (state_next == S_ADDR) begin
          tmo_cnt_next   = 4'd0;
          timed_out_next = 1'b0;
        end
      end
      S_ADDR: begin
        if (grant == OWNER_DATA) begin
          mem_addr_next = d_addr;
          r_w_next      = d_we ? RW_WRITE : RW_READ;
          if (d_we) mem_wdata_next = d_wdata;
        end else begin
          mem_addr_next = f_addr;
          r_w_next      = RW_READ;
        end
      end
      S_ACCESS: begin
        // Read data is only guaranteed while MFC is high, so grab it here.
        if (MFC) begin
          cap_data_next = mem_rdata;
        end else begin
          tmo_cnt_next = tmo_cnt + 4'd1;
          if (tmo_cnt == TMO_LAST) timed_out_next = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (R_W == RW_READ) begin
          if (grant == OWNER_DATA) d_rdata_next = cap_data;
          else                     f_rdata_next = cap_data;
        end
      end
      S_DONE: begin
        r_w_next = RW_READ;
        if (grant == OWNER_DATA) begin
          d_done_next = 1'b1;
          d_err_next  = timed_out;
        end else begin
          f_done_next = 1'b1;
          f_err_next  = timed_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= 4'd0;
      timed_out <= 1'b0;
      cap_data  <= 16'h0000;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      f_rdata   <= 16'h0000;
      d_rdata   <= 16'h0000;
      R_W       <= RW_READ;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
      f_done    <= 1'b0;
      f_err     <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_next;
      timed_out <= timed_out_next;
      cap_data  <= cap_data_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      f_rdata   <= f_rdata_next;
      d_rdata   <= d_rdata_next;
      R_W       <= r_w_next;
      mem_en    <= mem_en_next;
      busy      <= busy_next;
      f_done    <= f_done_next;
      f_err     <= f_err_next;
      d_done    <= d_done_next;
      d_err     <= d_err_next;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected
// completions, a negedge monitor pops and compares them on every done pulse.
module tb_mem_bus_arbiter;
  import mem_ctrl_pkg::*;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        f_done, f_err, d_done, d_err, mem_en, R_W, MFC, busy, grant;

  logic        mfc_enable;
  logic [15:0] mem_val;
  logic [15:0] model_f, model_d;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   en_count;
  logic        last_rw;
  logic [15:0] last_addr, last_wdata;
  int   lat;

  always #5 clk = ~clk;

  assign MFC       = mem_en & mfc_enable;
  assign mem_rdata = mem_en ? mem_val : 16'h0000;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_rdata   (f_rdata),
    .f_done    (f_done),
    .f_err     (f_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .R_W       (R_W),
    .MFC       (MFC),
    .busy      (busy),
    .grant     (grant)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: bus activity bookkeeping plus scoreboard compare on done pulses.
  always @(negedge clk) begin
    if (mem_en) begin
      en_count++;
      last_rw    = R_W;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
    if (f_done && d_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL both_done: got f_done=1 d_done=1, expected at most one");
    end else if (f_done || d_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done (d_done=%0b), expected none", d_done);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("done_owner", 16'(d_done), 16'(mon_e.owner));
        checkOutput("done_err", 16'(d_done ? d_err : f_err), 16'(mon_e.err));
        checkOutput("done_rdata", d_done ? d_rdata : f_rdata, mon_e.rdata);
      end
    end
  end

  // One transaction from a single requester; call at a negedge.
  task automatic applyStimulus(input logic is_data, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic mfc_ok,
                               input logic [15:0] rd_val, input logic short_req,
                               output int latency);
    exp_t e;
    mem_val    = rd_val;
    mfc_enable = mfc_ok;
    en_count   = 0;
    if (mfc_ok && !(is_data && we)) begin
      if (is_data) model_d = rd_val;
      else         model_f = rd_val;
    end
    e.owner = is_data;
    e.err   = !mfc_ok;
    e.rdata = is_data ? model_d : model_f;
    exp_q.push_back(e);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    latency = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (short_req) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
      if (f_done || d_done) begin
        latency = cyc - 1;
        break;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    if (latency < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait: got no done in 40 cycles, expected a done pulse");
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    mfc_enable = 1'b1; mem_val = 16'h0;
    model_f = 16'h0; model_d = 16'h0;
    en_count = 0;

    // Reset state
    #12;
    checkOutput("rst_mem_en", 16'(mem_en), 16'd0);
    checkOutput("rst_rw", 16'(R_W), 16'd1);
    checkOutput("rst_grant", 16'(grant), 16'd1);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'({f_done, d_done, f_err, d_err}), 16'd0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_f_rdata", f_rdata, 16'h0000);
    checkOutput("rst_d_rdata", d_rdata, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fetch read, MFC in first ACCESS cycle
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0, 1'b1, 16'h1234, 1'b0, lat);
    checkOutput("fetch_latency", 16'(lat), 16'd4);
    checkOutput("fetch_en_cycles", 16'(en_count), 16'd1);
    checkOutput("fetch_rw", 16'(last_rw), 16'd1);
    checkOutput("fetch_addr", last_addr, 16'h0010);

    // Data write
    applyStimulus(1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b1, 16'h7777, 1'b0, lat);
    checkOutput("write_rw", 16'(last_rw), 16'd0);
    checkOutput("write_en_cycles", 16'(en_count), 16'd1);
    checkOutput("write_addr", last_addr, 16'h0200);
    checkOutput("write_wdata", last_wdata, 16'hBEEF);
    checkOutput("write_rw_idle", 16'(R_W), 16'd1);

    // Data read leaves fetch data alone
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0, 1'b1, 16'hCAFE, 1'b0, lat);
    checkOutput("read_f_rdata_kept", f_rdata, 16'h1234);
    checkOutput("read_rw", 16'(last_rw), 16'd1);

    // Both requesting from reset: fetch, data, fetch, data
    reset = 1'b0;
    model_f = 16'h0; model_d = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rr_grant_reset", 16'(grant), 16'd1);
    mem_val = 16'h5A5A; mfc_enable = 1'b1;
    model_f = 16'h5A5A; model_d = 16'h5A5A;
    exp_q.push_back('{owner: 1'b0, err: 1'b0, rdata: 16'h5A5A});
    exp_q.push_back('{owner: 1'b1, err: 1'b0, rdata: 16'h5A5A});
    exp_q.push_back('{owner: 1'b0, err: 1'b0, rdata: 16'h5A5A});
    exp_q.push_back('{owner: 1'b1, err: 1'b0, rdata: 16'h5A5A});
    f_addr = 16'h0040; d_addr = 16'h0050; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 100 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (f_done || d_done) ndone++;
    end
    f_req = 1'b0; d_req = 1'b0;
    checkOutput("rr_done_count", 16'(ndone), 16'd4);

    // MFC never arrives: 15 ACCESS cycles then error completion
    applyStimulus(1'b0, 1'b0, 16'h0070, 16'h0, 1'b0, 16'hDEAD, 1'b0, lat);
    checkOutput("tmo_en_cycles", 16'(en_count), 16'd15);
    checkOutput("tmo_latency", 16'(lat), 16'd17);
    checkOutput("tmo_mem_en_after", 16'(mem_en), 16'd0);

    // Reset during ACCESS aborts without a done pulse
    mfc_enable = 1'b0;
    d_we = 1'b0; d_addr = 16'h0090; d_req = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 10 && !mem_en; cyc++) @(negedge clk);
    checkOutput("abort_in_access", 16'(mem_en), 16'd1);
    #2;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("abort_mem_en", 16'(mem_en), 16'd0);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    checkOutput("abort_d_rdata", d_rdata, 16'h0000);
    model_f = 16'h0; model_d = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0080, 16'h0, 1'b1, 16'h0F0F, 1'b0, lat);
    checkOutput("post_abort_latency", 16'(lat), 16'd4);
    checkOutput("post_abort_addr", last_addr, 16'h0080);

    // Request dropped after one cycle still completes
    applyStimulus(1'b0, 1'b0, 16'h00A0, 16'h0, 1'b1, 16'hABCD, 1'b1, lat);
    checkOutput("short_req_latency", 16'(lat), 16'd4);

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
